// File: rtl/expr_job_arbiter_if.sv
// Requester, parser and response channels of the expression job arbiter.
// The arbiter connects through the slave modport; the environment driving it uses master.
interface expr_job_arbiter_if;
    logic        req0_stb;
    logic [31:0] req0_data;
    logic        req0_op;
    logic        req0_last;
    logic        req0_ack;
    logic        req1_stb;
    logic [31:0] req1_data;
    logic        req1_op;
    logic        req1_last;
    logic        req1_ack;

    logic        par_stb;
    logic [31:0] par_data;
    logic        par_op;
    logic        par_ack;

    logic        res_in_stb;
    logic [31:0] res_in_data;
    logic        res_in_ack;

    logic        rsp_stb;
    logic [31:0] rsp_data;
    logic        rsp_id;
    logic        rsp_ack;

    modport slave (
        input  req0_stb, req0_data, req0_op, req0_last,
        output req0_ack,
        input  req1_stb, req1_data, req1_op, req1_last,
        output req1_ack,
        output par_stb, par_data, par_op,
        input  par_ack,
        input  res_in_stb, res_in_data,
        output res_in_ack,
        output rsp_stb, rsp_data, rsp_id,
        input  rsp_ack
    );

    modport master (
        output req0_stb, req0_data, req0_op, req0_last,
        input  req0_ack,
        output req1_stb, req1_data, req1_op, req1_last,
        input  req1_ack,
        input  par_stb, par_data, par_op,
        output par_ack,
        output res_in_stb, res_in_data,
        input  res_in_ack,
        input  rsp_stb, rsp_data, rsp_id,
        output rsp_ack
    );
endinterface

// File: rtl/expr_job_arbiter.sv
// Round-robin arbiter granting one of two requesters a whole expression job on the
// parser, then returning the parser result tagged with the requester index.
module expr_job_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    expr_job_arbiter_if.slave    bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     jobs_done
);

    typedef enum logic [1:0] {IDLE, FEED, WAIT_RES, RESP} state_t;

    state_t      state, state_nxt;
    logic        grant, grant_nxt;
    logic        prio;
    logic        rsp_stb_q;
    logic [31:0] rsp_data_q;

    logic        g_stb, g_op, g_last;
    logic [31:0] g_data;
    logic        res_hs, rsp_hs;

    always_comb begin
        g_stb  = grant ? bus.req1_stb  : bus.req0_stb;
        g_data = grant ? bus.req1_data : bus.req0_data;
        g_op   = grant ? bus.req1_op   : bus.req0_op;
        g_last = grant ? bus.req1_last : bus.req0_last;
    end

    // Combinational outputs are forced low while RST is high, even if the
    // registered state has not yet returned to IDLE.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        bus.req0_ack   = 1'b0;
        bus.req1_ack   = 1'b0;
        bus.par_stb    = 1'b0;
        bus.par_data   = '0;
        bus.par_op     = 1'b0;
        bus.res_in_ack = 1'b0;
        res_hs         = 1'b0;
        rsp_hs         = 1'b0;
        if (!RST) begin
            unique case (state)
                IDLE: begin
                    if (bus.req0_stb || bus.req1_stb) begin
                        grant_nxt = (bus.req0_stb && bus.req1_stb) ? prio : bus.req1_stb;
                        state_nxt = FEED;
                    end
                end
                FEED: begin
                    bus.par_stb  = g_stb;
                    bus.par_data = g_data;
                    bus.par_op   = g_op;
                    if (grant) bus.req1_ack = bus.par_ack;
                    else       bus.req0_ack = bus.par_ack;
                    if (g_stb && bus.par_ack && g_last) state_nxt = WAIT_RES;
                end
                WAIT_RES: begin
                    bus.res_in_ack = 1'b1;
                    res_hs         = bus.res_in_stb;
                    if (res_hs) state_nxt = RESP;
                end
                RESP: begin
                    rsp_hs = rsp_stb_q && bus.rsp_ack;
                    if (rsp_hs) state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            grant      <= 1'b0;
            prio       <= 1'b0;
            rsp_stb_q  <= 1'b0;
            rsp_data_q <= '0;
            jobs_done  <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            if (res_hs) begin
                rsp_data_q <= bus.res_in_data;
                rsp_stb_q  <= 1'b1;
            end
            if (rsp_hs) begin
                rsp_stb_q <= 1'b0;
                prio      <= ~grant;
                jobs_done <= jobs_done + CNT_W'(1);
            end
        end
    end

    assign bus.rsp_stb  = rsp_stb_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_id   = grant;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_expr_job_arbiter.sv
// Scoreboard bench for expr_job_arbiter: two token requesters, an RPN parser model
// that answers as soon as an expression reduces, and a response sink with stall control.
module tb_expr_job_arbiter;

    localparam int unsigned CNT_W  = 2;
    localparam logic [31:0] OP_ADD = 32'd0;
    localparam logic [31:0] OP_SUB = 32'd1;
    localparam logic [31:0] OP_END = 32'd2;

    typedef struct {
        logic [31:0] data;
        logic        op;
        logic        last;
        int unsigned gap;
    } tok_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } rsp_t;

    logic             CLK = 1'b0;
    logic             RST;
    logic             busy;
    logic [CNT_W-1:0] jobs_done;

    expr_job_arbiter_if bus();

    expr_job_arbiter #(.CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .busy      (busy),
        .jobs_done (jobs_done)
    );

    always #5 CLK = ~CLK;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    tok_t        q_req[2][$];
    tok_t        exp_tok[2][$];
    rsp_t        exp_rsp[$];
    int unsigned ack_mode  = 0;
    int unsigned rsp_hold  = 0;
    bit          early_chk = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void set_req(input int id, input logic stb, input tok_t t);
        if (id == 0) begin
            bus.req0_stb = stb; bus.req0_data = t.data; bus.req0_op = t.op; bus.req0_last = t.last;
        end else begin
            bus.req1_stb = stb; bus.req1_data = t.data; bus.req1_op = t.op; bus.req1_last = t.last;
        end
    endfunction

    function automatic logic req_ack(input int id);
        return (id == 0) ? bus.req0_ack : bus.req1_ack;
    endfunction

    // Requester: presents queued tokens in order, honouring per-token idle gaps.
    task automatic drive_req(input int id);
        tok_t        t;
        logic        stb;
        int unsigned stall = 0;
        t = '{data: 32'd0, op: 1'b0, last: 1'b0, gap: 0};
        set_req(id, 1'b0, t);
        forever begin
            @(posedge CLK); #1;
            stb = 1'b0;
            if (q_req[id].size() != 0) begin
                t = q_req[id][0];
                if (t.gap > 0) begin
                    t.gap--;
                    q_req[id][0] = t;
                end else begin
                    stb = 1'b1;
                end
            end
            set_req(id, stb, t);
            @(negedge CLK);
            if (RST) begin
                q_req[id].delete();
                stall = 0;
            end else if (stb && req_ack(id)) begin
                void'(q_req[id].pop_front());
                stall = 0;
            end else if (stb) begin
                stall++;
                if (stall >= 1000) begin
                    check_eq($sformatf("req%0d_stall", id), stall, 0);
                    q_req[id].delete();
                    stall = 0;
                end
            end
        end
    endtask

    initial drive_req(0);
    initial drive_req(1);

    // Parser model: RPN stack, result presented when an operator empties the stack.
    initial begin
        logic [31:0] st[$];
        logic        hs_par, hs_res, rst_s, o;
        logic [31:0] d, a, b, r;
        bus.par_ack     = 1'b0;
        bus.res_in_stb  = 1'b0;
        bus.res_in_data = '0;
        forever begin
            @(negedge CLK);
            rst_s  = RST;
            hs_par = bus.par_stb && bus.par_ack;
            hs_res = bus.res_in_stb && bus.res_in_ack;
            d      = bus.par_data;
            o      = bus.par_op;
            @(posedge CLK); #1;
            if (rst_s) begin
                st.delete();
                bus.res_in_stb = 1'b0;
            end else begin
                if (hs_res) bus.res_in_stb = 1'b0;
                if (hs_par) begin
                    if (!o) begin
                        st.push_back(d);
                    end else if (d != OP_END && st.size() >= 2) begin
                        b = st.pop_back();
                        a = st.pop_back();
                        r = (d == OP_ADD) ? a + b : a - b;
                        if (st.size() == 0) begin
                            bus.res_in_stb  = 1'b1;
                            bus.res_in_data = r;
                        end else begin
                            st.push_back(r);
                        end
                    end
                end
            end
            case (ack_mode)
                0:       bus.par_ack = 1'b1;
                1:       bus.par_ack = ~bus.par_ack;
                default: bus.par_ack = 1'b0;
            endcase
        end
    end

    // Response sink: holds off rsp_ack for rsp_hold cycles of each response.
    initial begin
        int unsigned held = 0;
        bus.rsp_ack = 1'b0;
        forever begin
            @(posedge CLK); #1;
            if (bus.rsp_stb) begin
                if (held < rsp_hold) begin
                    bus.rsp_ack = 1'b0;
                    held++;
                end else begin
                    bus.rsp_ack = 1'b1;
                end
            end else begin
                bus.rsp_ack = 1'b0;
                held = 0;
            end
        end
    end

    // Monitor: token order per requester, response order/stability, completed-job count.
    initial begin
        tok_t        t;
        rsp_t        r;
        int          src;
        bit          prev_hold  = 1'b0;
        bit          jd_pending = 1'b0;
        logic [31:0] prev_data  = '0;
        logic        prev_id    = 1'b0;
        int unsigned model_jd   = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                exp_tok[0].delete();
                exp_tok[1].delete();
                exp_rsp.delete();
                prev_hold  = 1'b0;
                jd_pending = 1'b0;
                model_jd   = 0;
            end else begin
                if (jd_pending) begin
                    check_eq("jobs_done", 32'(jobs_done), model_jd);
                    jd_pending = 1'b0;
                end
                if (bus.par_stb && bus.par_ack) begin
                    check_eq("ack_onehot", 32'(bus.req0_ack) + 32'(bus.req1_ack), 1);
                    src = bus.req1_ack ? 1 : 0;
                    check_eq($sformatf("tok%0d_pending", src), 32'(exp_tok[src].size() != 0), 1);
                    if (exp_tok[src].size() != 0) begin
                        t = exp_tok[src].pop_front();
                        check_eq($sformatf("tok%0d_data", src), bus.par_data, t.data);
                        check_eq($sformatf("tok%0d_op", src), 32'(bus.par_op), 32'(t.op));
                    end
                end
                if (early_chk && bus.res_in_stb && exp_tok[0].size() != 0)
                    check_eq("early_res_ack", 32'(bus.res_in_ack), 0);
                if (prev_hold) begin
                    check_eq("rsp_hold_stb", 32'(bus.rsp_stb), 1);
                    check_eq("rsp_hold_data", bus.rsp_data, prev_data);
                    check_eq("rsp_hold_id", 32'(bus.rsp_id), 32'(prev_id));
                end
                if (bus.rsp_stb && bus.rsp_ack) begin
                    check_eq("rsp_pending", 32'(exp_rsp.size() != 0), 1);
                    if (exp_rsp.size() != 0) begin
                        r = exp_rsp.pop_front();
                        check_eq("rsp_data", bus.rsp_data, r.data);
                        check_eq("rsp_id", 32'(bus.rsp_id), 32'(r.id));
                    end
                    model_jd   = (model_jd + 1) % (1 << CNT_W);
                    jd_pending = 1'b1;
                end
                prev_hold = bus.rsp_stb && !bus.rsp_ack;
                prev_data = bus.rsp_data;
                prev_id   = bus.rsp_id;
            end
        end
    end

    task automatic push_tok(input int id, input tok_t t);
        q_req[id].push_back(t);
        exp_tok[id].push_back(t);
    endtask

    task automatic push_job(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] opc, input int unsigned gap_b,
                            input int unsigned gap_op, input bit with_end);
        rsp_t r;
        push_tok(id, '{data: a,   op: 1'b0, last: 1'b0,      gap: 0});
        push_tok(id, '{data: b,   op: 1'b0, last: 1'b0,      gap: gap_b});
        push_tok(id, '{data: opc, op: 1'b1, last: !with_end, gap: gap_op});
        if (with_end) push_tok(id, '{data: OP_END, op: 1'b1, last: 1'b1, gap: 4});
        r.id   = 1'(id);
        r.data = (opc == OP_ADD) ? a + b : a - b;
        exp_rsp.push_back(r);
    endtask

    task automatic wait_drain();
        for (int unsigned i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (q_req[0].size() == 0 && q_req[1].size() == 0 && exp_rsp.size() == 0 && !busy) break;
        end
        check_eq("drain_left", 32'(exp_rsp.size() + q_req[0].size() + q_req[1].size()), 0);
        repeat (2) @(negedge CLK);
    endtask

    task automatic apply_reset();
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        int unsigned jd_seq[5] = '{1, 2, 3, 0, 1};
        bit          seen;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_jobs_done", 32'(jobs_done), 0);
        check_eq("rst_rsp_stb", 32'(bus.rsp_stb), 0);
        check_eq("rst_rsp_data", bus.rsp_data, 0);
        check_eq("rst_rsp_id", 32'(bus.rsp_id), 0);
        check_eq("rst_par_stb", 32'(bus.par_stb), 0);
        check_eq("rst_res_in_ack", 32'(bus.res_in_ack), 0);
        @(posedge CLK); #1 RST = 1'b0;

        // Single job: 3 4 + -> 7 from requester 0.
        push_job(0, 32'd3, 32'd4, OP_ADD, 0, 0, 1'b0);
        wait_drain();
        check_eq("single_jobs_done", 32'(jobs_done), 1);

        // Contention after reset: req0, then req1 (prio flipped), then req0's second job.
        apply_reset();
        push_job(0, 32'd10, 32'd1, OP_ADD, 3, 0, 1'b0);
        push_job(1, 32'd20, 32'd2, OP_SUB, 0, 0, 1'b0);
        push_job(0, 32'd30, 32'd3, OP_ADD, 0, 0, 1'b0);
        wait_drain();

        // Backpressure: toggling par_ack, 10-cycle response stall, req1 waiting meanwhile.
        ack_mode = 1;
        rsp_hold = 10;
        push_job(0, 32'd100, 32'd23, OP_SUB, 0, 0, 1'b0);
        repeat (4) @(negedge CLK);
        push_job(1, 32'd5, 32'd6, OP_ADD, 0, 0, 1'b0);
        wait_drain();
        ack_mode = 0;
        rsp_hold = 0;

        // Early result: parser answers after SUB while END is still pending.
        early_chk = 1'b1;
        push_job(0, 32'd8, 32'd2, OP_SUB, 0, 0, 1'b1);
        wait_drain();
        early_chk = 1'b0;

        // Reset in FEED after two tokens, with the third token stalled on par_ack.
        push_job(0, 32'd1, 32'd2, OP_ADD, 0, 8, 1'b0);
        seen = 1'b0;
        for (int unsigned i = 0; i < 200; i++) begin
            @(posedge CLK); #2;
            if (exp_tok[0].size() == 1) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("two_tokens_seen", 32'(seen), 1);
        ack_mode = 2;
        repeat (12) @(posedge CLK);
        @(negedge CLK);
        check_eq("feed_stall_stb", 32'(bus.par_stb), 1);
        @(posedge CLK); #1;
        RST      = 1'b1;
        ack_mode = 0;
        @(negedge CLK);
        check_eq("rst_gate_par_stb", 32'(bus.par_stb), 0);
        check_eq("rst_gate_req0_ack", 32'(bus.req0_ack), 0);
        check_eq("rst_gate_res_in_ack", 32'(bus.res_in_ack), 0);
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_par_stb", 32'(bus.par_stb), 0);
        check_eq("abort_jobs_done", 32'(jobs_done), 0);
        check_eq("abort_rsp_stb", 32'(bus.rsp_stb), 0);
        check_eq("abort_rsp_data", bus.rsp_data, 0);

        // Counter wrap with a 2-bit jobs_done: 1, 2, 3, 0, 1.
        for (int k = 0; k < 5; k++) begin
            push_job(k % 2, 32'(k * 7 + 9), 32'(k + 1), (k % 2 == 1) ? OP_SUB : OP_ADD, 0, 0, 1'b0);
            wait_drain();
            check_eq($sformatf("wrap_jd%0d", k), 32'(jobs_done), jd_seq[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
